// File: rtl/lcd_cmd_scheduler_pkg.sv
// Shared types and constants for the HD44780 write scheduler:
// state encodings, the power-on init command list and command classification.
package lcd_pkg;

  typedef enum logic [2:0] {
    POWERON,
    INIT_ISSUE,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_e;

  // Top-level sequencing; C_XFER covers the whole SETUP..WAIT engine run.
  typedef enum logic [1:0] {
    C_POWERON,
    C_INIT_ISSUE,
    C_IDLE,
    C_XFER
  } ctrl_e;

  localparam int INIT_COUNT = 4;

  // 8-bit/2-line function set, display on, entry mode increment, clear.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long busy wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_cmd_scheduler_if.sv
// Requester ports and LCD bus of the scheduler bundled as one interface.
// Handshake: a requester raises reqN_valid with reqN_rs/reqN_data stable and
// holds them until reqN_ready is high in a cycle; that cycle is the transfer.
interface lcd_cmd_scheduler_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       lcd_e;
  logic       lcd_rw;
  logic       lcd_rs;
  logic [7:0] lcd_data;

  modport master (
    output req0_valid, req0_rs, req0_data,
    input  req0_ready,
    output req1_valid, req1_rs, req1_data,
    input  req1_ready,
    input  lcd_e, lcd_rw, lcd_rs, lcd_data
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data,
    output req0_ready,
    input  req1_valid, req1_rs, req1_data,
    output req1_ready,
    output lcd_e, lcd_rw, lcd_rs, lcd_data
  );
endinterface

// File: rtl/lcd_cmd_scheduler_bus_timer.sv
// LCD bus timing engine: owns the single down-counter, the post-reset wait
// and the SETUP/PULSE/HOLD/WAIT sequence of one write, with registered outputs.
module lcd_bus_timer
  import lcd_pkg::*;
#(
  parameter int T_POWERON = 2000000,
  parameter int T_SETUP   = 4,
  parameter int T_PULSE   = 25,
  parameter int T_HOLD    = 4,
  parameter int T_CMD     = 2500,
  parameter int T_LONG    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       start_rs,
  input  logic [7:0] start_data,
  output logic       done,
  output lcd_state_e phase,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int T_MAX = (T_POWERON > T_LONG) ? T_POWERON : T_LONG;
  localparam int CW    = $clog2(T_MAX + 1);
  typedef logic [CW-1:0] cnt_t;

  cnt_t       cnt;
  cnt_t       cnt_nxt;
  lcd_state_e phase_nxt;

  // Each phase loads its length minus one on entry and leaves when it hits zero.
  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = (cnt != '0) ? cnt - cnt_t'(1) : cnt;
    done      = 1'b0;
    case (phase)
      IDLE: begin
        if (start) begin
          phase_nxt = SETUP;
          cnt_nxt   = cnt_t'(T_SETUP - 1);
        end
      end
      POWERON: begin
        if (cnt == '0) begin
          done      = 1'b1;
          phase_nxt = IDLE;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          phase_nxt = PULSE;
          cnt_nxt   = cnt_t'(T_PULSE - 1);
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          phase_nxt = HOLD;
          cnt_nxt   = cnt_t'(T_HOLD - 1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          phase_nxt = WAIT;
          cnt_nxt   = is_long_cmd(lcd_rs, lcd_data) ? cnt_t'(T_LONG - 1)
                                                    : cnt_t'(T_CMD - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          done      = 1'b1;
          phase_nxt = IDLE;
        end
      end
      default: phase_nxt = IDLE;
    endcase
  end

  // lcd_e is registered from the next phase so it is high exactly in PULSE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= POWERON;
      cnt      <= cnt_t'(T_POWERON - 1);
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
      lcd_e <= (phase_nxt == PULSE);
      if (phase == IDLE && start) begin
        lcd_rs   <= start_rs;
        lcd_data <= start_data;
      end
    end
  end

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// HD44780 write scheduler: power-on wait, init command sequence, then
// round-robin sharing of the LCD between two requesters.
module lcd_cmd_scheduler
  import lcd_pkg::*;
#(
  parameter int T_POWERON = 2000000,
  parameter int T_SETUP   = 4,
  parameter int T_PULSE   = 25,
  parameter int T_HOLD    = 4,
  parameter int T_CMD     = 2500,
  parameter int T_LONG    = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_cmd_scheduler_if.slave   bus,
  output logic                 init_done,
  output logic                 busy,
  output lcd_state_e           state
);

  ctrl_e      ctrl;
  ctrl_e      ctrl_nxt;
  logic [1:0] idx;
  logic [1:0] idx_nxt;
  logic       last;      // requester served most recently
  logic       last_nxt;
  logic       done_nxt;
  logic       grant0;
  logic       grant1;
  logic       start;
  logic       start_rs;
  logic [7:0] start_data;
  logic       tm_done;
  lcd_state_e tm_phase;
  logic       tm_e;
  logic       tm_rs;
  logic [7:0] tm_data;

  always_comb begin
    ctrl_nxt   = ctrl;
    idx_nxt    = idx;
    last_nxt   = last;
    done_nxt   = init_done;
    grant0     = 1'b0;
    grant1     = 1'b0;
    start      = 1'b0;
    start_rs   = 1'b0;
    start_data = 8'h00;
    case (ctrl)
      C_POWERON: begin
        if (tm_done) ctrl_nxt = C_INIT_ISSUE;
      end
      C_INIT_ISSUE: begin
        start      = 1'b1;
        start_data = init_cmd(idx);
        ctrl_nxt   = C_XFER;
      end
      C_IDLE: begin
        if (init_done) begin
          if (bus.req0_valid && (!bus.req1_valid || last)) grant0 = 1'b1;
          else if (bus.req1_valid)                         grant1 = 1'b1;
          if (grant0) begin
            start      = 1'b1;
            start_rs   = bus.req0_rs;
            start_data = bus.req0_data;
            last_nxt   = 1'b0;
            ctrl_nxt   = C_XFER;
          end else if (grant1) begin
            start      = 1'b1;
            start_rs   = bus.req1_rs;
            start_data = bus.req1_data;
            last_nxt   = 1'b1;
            ctrl_nxt   = C_XFER;
          end
        end
      end
      C_XFER: begin
        if (tm_done) begin
          if (init_done) begin
            ctrl_nxt = C_IDLE;
          end else if (idx == 2'(INIT_COUNT - 1)) begin
            ctrl_nxt = C_IDLE;
            done_nxt = 1'b1;
          end else begin
            idx_nxt  = idx + 2'd1;
            ctrl_nxt = C_INIT_ISSUE;
          end
        end
      end
      default: ctrl_nxt = C_POWERON;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl      <= C_POWERON;
      idx       <= 2'd0;
      last      <= 1'b1;
      init_done <= 1'b0;
    end else begin
      ctrl      <= ctrl_nxt;
      idx       <= idx_nxt;
      last      <= last_nxt;
      init_done <= done_nxt;
    end
  end

  // During a transfer the visible state is whatever phase the engine is in.
  always_comb begin
    case (ctrl)
      C_POWERON:    state = POWERON;
      C_INIT_ISSUE: state = INIT_ISSUE;
      C_IDLE:       state = IDLE;
      default:      state = tm_phase;
    endcase
  end

  assign busy           = (state != IDLE);
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.lcd_e      = tm_e;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_rs     = tm_rs;
  assign bus.lcd_data   = tm_data;

  lcd_bus_timer #(
    .T_POWERON (T_POWERON),
    .T_SETUP   (T_SETUP),
    .T_PULSE   (T_PULSE),
    .T_HOLD    (T_HOLD),
    .T_CMD     (T_CMD),
    .T_LONG    (T_LONG)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_rs   (start_rs),
    .start_data (start_data),
    .done       (tm_done),
    .phase      (tm_phase),
    .lcd_e      (tm_e),
    .lcd_rs     (tm_rs),
    .lcd_data   (tm_data)
  );

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Bench for lcd_cmd_scheduler: a timeline model predicts every output each
// cycle; directed phases pin init, arbitration, wait lengths and async reset.
module tb_lcd_cmd_scheduler;
  import lcd_pkg::*;

  localparam int TPO = 10;
  localparam int TS  = 2;
  localparam int TP  = 3;
  localparam int TH  = 2;
  localparam int TC  = 5;
  localparam int TL  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done;
  logic       busy;
  lcd_state_e state;

  lcd_cmd_scheduler_if bus();

  lcd_cmd_scheduler #(
    .T_POWERON (TPO), .T_SETUP (TS), .T_PULSE (TP),
    .T_HOLD    (TH),  .T_CMD   (TC), .T_LONG  (TL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .init_done (init_done),
    .busy      (busy),
    .state     (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (timeline arithmetic) ----------------
  logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  int         rel;           // cycles since reset release
  int         m_next_free, m_init_idx, m_last, m_start;
  bit         m_done, m_have, m_rs, m_bus_rs;
  logic [7:0] m_data, m_bus_data;
  logic [7:0] exp_q [$];     // bytes expected on the next E pulses

  bit         seen_r0, seen_r1, prev_e, prev_done;
  int         e_rise_q [$];
  logic [7:0] rise_d_q [$];
  int         r0_q [$];
  int         r1_q [$];
  int         done_rel = -1;
  int         e_hi_cnt, e_hi_at_done;

  task automatic start_write(input bit rs, input logic [7:0] d);
    m_have      = 1'b1;
    m_start     = rel;
    m_rs        = rs;
    m_data      = d;
    m_next_free = rel + 1 + TS + TP + TH + ((!rs && d <= 8'h03) ? TL : TC);
    exp_q.push_back(d);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit x_e, x_r0, x_r1, idle;
    if (!rst) begin
      chk("rst_lcd_e", bus.lcd_e, 0);
      chk("rst_lcd_rs", bus.lcd_rs, 0);
      chk("rst_lcd_data", bus.lcd_data, 0);
      chk("rst_lcd_rw", bus.lcd_rw, 0);
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_busy", busy, 1);
      chk("rst_state", state, POWERON);
      m_next_free = TPO; m_init_idx = 0; m_last = 1;
      m_done = 0; m_have = 0; m_bus_rs = 0; m_bus_data = 8'h00;
      exp_q.delete();
      rel = 0; prev_e = 0; prev_done = 0; e_hi_cnt = 0;
    end else begin
      if (m_have && rel == m_start + 1) begin
        m_bus_rs   = m_rs;
        m_bus_data = m_data;
      end
      if (!m_done && m_init_idx == 4 && rel >= m_next_free) m_done = 1;
      idle = m_done && rel >= m_next_free;
      x_e  = m_have && rel >= m_start + 1 + TS && rel <= m_start + TS + TP;
      x_r0 = 0;
      x_r1 = 0;
      if (!m_done && m_init_idx < 4 && rel == m_next_free) begin
        start_write(1'b0, init_tab[m_init_idx]);
        m_init_idx++;
      end else if (idle) begin
        if (bus.req0_valid && (!bus.req1_valid || m_last == 1)) begin
          x_r0 = 1; m_last = 0; start_write(bus.req0_rs, bus.req0_data);
        end else if (bus.req1_valid) begin
          x_r1 = 1; m_last = 1; start_write(bus.req1_rs, bus.req1_data);
        end
      end
      chk("lcd_e", bus.lcd_e, x_e);
      chk("lcd_rs", bus.lcd_rs, m_bus_rs);
      chk("lcd_data", bus.lcd_data, m_bus_data);
      chk("lcd_rw", bus.lcd_rw, 0);
      chk("req0_ready", bus.req0_ready, x_r0);
      chk("req1_ready", bus.req1_ready, x_r1);
      chk("init_done", init_done, m_done);
      chk("busy", busy, !idle);
      if (bus.lcd_e && !prev_e) begin
        e_rise_q.push_back(rel);
        rise_d_q.push_back(bus.lcd_data);
        if (exp_q.size() == 0) chk("e_pulse_unexpected", 1, 0);
        else                   chk("e_pulse_byte", bus.lcd_data, exp_q.pop_front());
      end
      if (bus.lcd_e) e_hi_cnt++;
      if (init_done && !prev_done) begin
        done_rel     = rel;
        e_hi_at_done = e_hi_cnt;
      end
      if (bus.req0_ready) r0_q.push_back(rel);
      if (bus.req1_ready) r1_q.push_back(rel);
      prev_e    = bus.lcd_e;
      prev_done = init_done;
      rel++;
    end
    seen_r0 = bus.req0_ready;
    seen_r1 = bus.req1_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_r1(input int n, input string name);
    int k = 0;
    while (r1_q.size() < n && k < 300) begin
      tick();
      k++;
    end
    if (r1_q.size() < n) chk(name, 0, 1);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done_rel < 0 && k < 400) begin
      tick();
      k++;
    end
    if (done_rel < 0) chk(name, 0, 1);
  endtask

  task automatic rand_byte(output logic rs, output logic [7:0] d);
    rs = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(0, 3));
    else                           d = 8'($urandom_range(0, 255));
  endtask

  task automatic rand_drive(input int n);
    logic       r;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      tick();
      if (!bus.req0_valid || seen_r0) begin
        bus.req0_valid = ($urandom_range(0, 2) == 0);
        rand_byte(r, d);
        bus.req0_rs = r; bus.req0_data = d;
      end
      if (!bus.req1_valid || seen_r1) begin
        bus.req1_valid = ($urandom_range(0, 2) == 0);
        rand_byte(r, d);
        bus.req1_rs = r; bus.req1_data = d;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    bus.req0_valid = 0; bus.req0_rs = 0; bus.req0_data = 8'h00;
    bus.req1_valid = 0; bus.req1_rs = 0; bus.req1_data = 8'h00;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // valid rises together with reset release
    rst = 1'b1;
    bus.req0_valid = 1; bus.req0_rs = 1; bus.req0_data = 8'h41;
    bus.req1_valid = 1; bus.req1_rs = 0; bus.req1_data = 8'h01;
    wait_r1(2, "timeout_alternation");
    chk("init_done_cycle", done_rel, 77);
    chk("init_e_high_cycles", e_hi_at_done, 12);
    if (e_rise_q.size() >= 6 && r0_q.size() >= 2 && r1_q.size() >= 2) begin
      chk("init_byte0", rise_d_q[0], 8'h38);
      chk("init_byte1", rise_d_q[1], 8'h0C);
      chk("init_byte2", rise_d_q[2], 8'h06);
      chk("init_byte3", rise_d_q[3], 8'h01);
      chk("init_e_rise0", e_rise_q[0], 13);
      chk("init_e_rise3", e_rise_q[3], 52);
      chk("clear_to_done", done_rel - (e_rise_q[3] - 1 - TS), 28);
      chk("first_grant_req0", r0_q[0], 77);
      chk("grant_req1", r1_q[0], 90);
      chk("grant_req0_again", r0_q[1], 118);
      chk("grant_req1_again", r1_q[1], 131);
      chk("write_e_rise", e_rise_q[4], 80);
      chk("write_byte", rise_d_q[4], 8'h41);
    end else chk("alternation_log_size", 0, 1);

    // wait lengths: short data write then long home command
    tick();
    bus.req0_valid = 0;
    bus.req1_rs = 1; bus.req1_data = 8'h01;
    r1_q.delete();
    wait_r1(1, "timeout_short");
    bus.req1_rs = 0; bus.req1_data = 8'h03;
    wait_r1(2, "timeout_home");
    bus.req1_rs = 1; bus.req1_data = 8'h55;
    wait_r1(3, "timeout_after_home");
    bus.req1_valid = 0;
    bus.req1_data  = 8'hA5;
    if (r1_q.size() >= 3) begin
      chk("short_wait_period", r1_q[1] - r1_q[0], 13);
      chk("long_wait_period", r1_q[2] - r1_q[1], 28);
    end

    rand_drive(1500);

    // asynchronous reset in the middle of an E pulse
    bus.req0_valid = 1; bus.req0_rs = 1; bus.req0_data = 8'h5A;
    bus.req1_valid = 1; bus.req1_rs = 1; bus.req1_data = 8'h33;
    k = 0;
    while (bus.lcd_e !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    chk("reached_pulse", bus.lcd_e, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_lcd_e_low", bus.lcd_e, 0);
    chk("async_init_done_low", init_done, 0);
    e_rise_q.delete();
    rise_d_q.delete();
    done_rel = -1;
    tick();
    tick();
    rst = 1'b1;
    wait_done("timeout_reinit");
    chk("reinit_done_cycle", done_rel, 77);
    if (e_rise_q.size() >= 1) begin
      chk("reinit_e_rise0", e_rise_q[0], 13);
      chk("reinit_byte0", rise_d_q[0], 8'h38);
    end else chk("reinit_log_size", 0, 1);

    rand_drive(300);
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
